// File: rtl/rule_sequencer_pkg.sv
// Shared types for the rule sequencer: rule table entry layout, compare symbols, FSM states.
package rule_sequencer_pkg;

    typedef enum logic [2:0] {
        SYM_EQ = 3'd0,
        SYM_GT = 3'd1,
        SYM_LT = 3'd2,
        SYM_GE = 3'd3,
        SYM_LE = 3'd4
    } rule_sym_e;

    // MSB-first packing; the host writes entries in exactly this layout.
    typedef struct packed {
        logic [15:0] byte_off;
        logic [2:0]  symbol;
        logic [7:0]  value;
        logic [7:0]  tx_addr;
        logic [15:0] pkt_len;
    } rule_entry_t;

    localparam int ENTRY_W = $bits(rule_entry_t);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_REPORT
    } state_e;

endpackage

// File: rtl/rule_sequencer_if.sv
// Host config, packet start, comparator and transmitter signals of the rule sequencer.
interface rule_sequencer_if
    import rule_sequencer_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
);
    logic               cfg_wr_en;
    logic [ADDR_W-1:0]  cfg_wr_addr;
    logic [ENTRY_W-1:0] cfg_wr_data;
    logic               cfg_cnt_wr_en;
    logic [ADDR_W:0]    cfg_cnt;
    logic               cfg_ready_o;
    logic               pkt_start_i;
    logic               rule_valid_o;
    logic               rule_ready_i;
    logic [15:0]        rule_byte_o;
    logic [2:0]         rule_symbol_o;
    logic [7:0]         rule_value_o;
    logic               res_valid_i;
    logic               res_hit_i;
    logic               match_valid_o;
    logic               match_ready_i;
    logic [7:0]         match_addr_o;
    logic [15:0]        match_pkt_len_o;
    logic               busy_o;
    logic [CNT_W-1:0]   drop_cnt_o;

    // slave: the sequencer itself
    modport slave (
        input  cfg_wr_en, cfg_wr_addr, cfg_wr_data, cfg_cnt_wr_en, cfg_cnt,
        input  pkt_start_i, rule_ready_i, res_valid_i, res_hit_i, match_ready_i,
        output cfg_ready_o, rule_valid_o, rule_byte_o, rule_symbol_o, rule_value_o,
        output match_valid_o, match_addr_o, match_pkt_len_o, busy_o, drop_cnt_o
    );

    // master: host, comparator and transmitter side
    modport master (
        output cfg_wr_en, cfg_wr_addr, cfg_wr_data, cfg_cnt_wr_en, cfg_cnt,
        output pkt_start_i, rule_ready_i, res_valid_i, res_hit_i, match_ready_i,
        input  cfg_ready_o, rule_valid_o, rule_byte_o, rule_symbol_o, rule_value_o,
        input  match_valid_o, match_addr_o, match_pkt_len_o, busy_o, drop_cnt_o
    );
endinterface

// File: rtl/rule_sequencer_ram.sv
// Simple dual-port block RAM holding the rule table; 1-cycle registered read, no reset on contents.
module my_block_ram #(
    parameter int DATA_WIDTH = 51,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);
    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        o_rdata <= r_mem[i_raddr];
    end
endmodule

// File: rtl/rule_sequencer.sv
// Walks the rule table for each packet, issuing one rule at a time to the comparator;
// the first hit's tx address and length are handed to the transmitter.
module rule_sequencer
    import rule_sequencer_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic clk,
    input  logic rst,
    rule_sequencer_if.slave bus
);
    state_e             r_state, w_next;
    logic [ADDR_W:0]    r_rule_count, r_rule_idx;
    rule_entry_t        r_entry, w_rd_entry;
    logic [ENTRY_W-1:0] w_rd_raw;
    logic [ADDR_W-1:0]  w_rd_addr;
    logic [7:0]         r_match_addr;
    logic [15:0]        r_match_len;
    logic [CNT_W-1:0]   r_drop_cnt;
    logic               w_idle, w_last;

    assign w_idle     = (r_state == S_IDLE);
    assign w_last     = (r_rule_idx == r_rule_count - 1'b1);
    assign w_rd_entry = rule_entry_t'(w_rd_raw);

    // Read address leads the FSM by one cycle so the entry is on the RAM output
    // for the whole FETCH cycle: 0 from IDLE, idx+1 while a miss may advance.
    always_comb begin
        w_rd_addr = r_rule_idx[ADDR_W-1:0];
        case (r_state)
            S_IDLE:  w_rd_addr = '0;
            S_WAIT:  w_rd_addr = r_rule_idx[ADDR_W-1:0] + 1'b1;
            default: w_rd_addr = r_rule_idx[ADDR_W-1:0];
        endcase
    end

    my_block_ram #(
        .DATA_WIDTH (ENTRY_W),
        .ADDR_WIDTH (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (bus.cfg_wr_en && w_idle),
        .i_waddr (bus.cfg_wr_addr),
        .i_wdata (bus.cfg_wr_data),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rd_raw)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (bus.pkt_start_i && r_rule_count != '0) w_next = S_FETCH;
            S_FETCH:  w_next = S_ISSUE;
            S_ISSUE:  if (bus.rule_ready_i) w_next = S_WAIT;
            S_WAIT:   if (bus.res_valid_i) begin
                          if (bus.res_hit_i) w_next = S_REPORT;
                          else if (w_last)   w_next = S_IDLE;
                          else               w_next = S_FETCH;
                      end
            S_REPORT: if (bus.match_ready_i) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rule_count <= '0;
            r_rule_idx   <= '0;
            r_entry      <= '0;
            r_match_addr <= '0;
            r_match_len  <= '0;
            r_drop_cnt   <= '0;
        end else begin
            if (w_idle && bus.cfg_cnt_wr_en) r_rule_count <= bus.cfg_cnt;
            case (r_state)
                S_IDLE:  if (bus.pkt_start_i) r_rule_idx <= '0;
                S_FETCH: r_entry <= w_rd_entry;
                S_WAIT:  if (bus.res_valid_i) begin
                             if (bus.res_hit_i) begin
                                 r_match_addr <= r_entry.tx_addr;
                                 r_match_len  <= r_entry.pkt_len;
                             end else if (!w_last) begin
                                 r_rule_idx <= r_rule_idx + 1'b1;
                             end
                         end
                default: ;
            endcase
            if (bus.pkt_start_i && !w_idle && r_drop_cnt != '1)
                r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    assign bus.cfg_ready_o     = w_idle;
    assign bus.busy_o          = !w_idle;
    assign bus.rule_valid_o    = (r_state == S_ISSUE);
    assign bus.rule_byte_o     = r_entry.byte_off;
    assign bus.rule_symbol_o   = r_entry.symbol;
    assign bus.rule_value_o    = r_entry.value;
    assign bus.match_valid_o   = (r_state == S_REPORT);
    assign bus.match_addr_o    = r_match_addr;
    assign bus.match_pkt_len_o = r_match_len;
    assign bus.drop_cnt_o      = r_drop_cnt;
endmodule

// File: tb/tb_rule_sequencer.sv
// Scoreboard bench for rule_sequencer: expected issues/matches are queued by the stimulus
// and popped by monitors on each handshake; a responder models the comparator.
module tb_rule_sequencer;
    import rule_sequencer_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rule_sequencer_if #(.ADDR_W(8), .CNT_W(16)) bus ();

    rule_sequencer #(.ADDR_W(8), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int res_lat  = 1;

    rule_entry_t exp_rule_q[$];
    logic [23:0] exp_match_q[$];
    bit          hit_q[$];

    rule_entry_t R0, R1, R2;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Rule issue monitor
    always @(negedge clk) begin
        if (!rst && bus.rule_valid_o && bus.rule_ready_i) begin
            rule_entry_t e;
            if (exp_rule_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_issue: byte=0x%0h", bus.rule_byte_o);
            end else begin
                e = exp_rule_q.pop_front();
                chk("rule_fields", {bus.rule_byte_o, bus.rule_symbol_o, bus.rule_value_o},
                    {e.byte_off, e.symbol, e.value});
            end
        end
    end

    // Match monitor
    always @(negedge clk) begin
        if (!rst && bus.match_valid_o && bus.match_ready_i) begin
            if (exp_match_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_match: addr=0x%0h len=%0d", bus.match_addr_o, bus.match_pkt_len_o);
            end else begin
                chk("match_fields", {bus.match_addr_o, bus.match_pkt_len_o}, exp_match_q.pop_front());
            end
        end
    end

    // Comparator model: answers each accepted rule after res_lat cycles
    initial begin
        bit h;
        forever begin
            @(negedge clk);
            if (!rst && bus.rule_valid_o && bus.rule_ready_i) begin
                h = (hit_q.size() != 0) ? hit_q.pop_front() : 1'b0;
                repeat (res_lat) @(posedge clk);
                #1 bus.res_valid_i = 1'b1; bus.res_hit_i = h;
                @(posedge clk);
                #1 bus.res_valid_i = 1'b0; bus.res_hit_i = 1'b0;
            end
        end
    end

    function automatic bit cond(input int what);
        case (what)
            0:       return !bus.busy_o;
            1:       return bus.rule_valid_o;
            2:       return bus.match_valid_o;
            default: return bus.rule_valid_o && bus.rule_ready_i;
        endcase
    endfunction

    task automatic wait_for(input string name, input int what, input int budget);
        bit ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (cond(what)) begin ok = 1'b1; break; end
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: timeout after %0d cycles", name, budget);
        end
    endtask

    task automatic load_rule(input int addr, input rule_entry_t e);
        @(posedge clk); #1;
        bus.cfg_wr_en = 1'b1; bus.cfg_wr_addr = 8'(addr); bus.cfg_wr_data = e;
        @(posedge clk); #1;
        bus.cfg_wr_en = 1'b0;
    endtask

    task automatic set_count(input int n);
        @(posedge clk); #1;
        bus.cfg_cnt_wr_en = 1'b1; bus.cfg_cnt = 9'(n);
        @(posedge clk); #1;
        bus.cfg_cnt_wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 bus.pkt_start_i = 1'b1;
        @(posedge clk); #1 bus.pkt_start_i = 1'b0;
    endtask

    function automatic rule_entry_t mk(input int i);
        rule_entry_t e;
        e.byte_off = 16'(i);
        e.symbol   = 3'(i % 5);
        e.value    = 8'(i) ^ 8'hA5;
        e.tx_addr  = 8'(i) ^ 8'h3C;
        e.pkt_len  = 16'(i * 3 + 7);
        return e;
    endfunction

    initial begin
        R0 = '{byte_off: 16'h0010, symbol: SYM_EQ, value: 8'h41, tx_addr: 8'h20, pkt_len: 16'd64};
        R1 = '{byte_off: 16'h0022, symbol: SYM_GE, value: 8'h7F, tx_addr: 8'h80, pkt_len: 16'd1500};
        R2 = '{byte_off: 16'h0100, symbol: SYM_LE, value: 8'h05, tx_addr: 8'hF0, pkt_len: 16'd9};

        bus.cfg_wr_en = 0; bus.cfg_wr_addr = '0; bus.cfg_wr_data = '0;
        bus.cfg_cnt_wr_en = 0; bus.cfg_cnt = '0; bus.pkt_start_i = 0;
        bus.rule_ready_i = 1; bus.res_valid_i = 0; bus.res_hit_i = 0; bus.match_ready_i = 1;

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_cfg_ready", bus.cfg_ready_o, 1);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_valids", {bus.rule_valid_o, bus.match_valid_o}, 0);
        chk("rst_data", {bus.rule_byte_o, bus.rule_symbol_o, bus.rule_value_o,
                         bus.match_addr_o, bus.match_pkt_len_o}, 0);
        chk("rst_drop", bus.drop_cnt_o, 0);

        // 3 rules, rule 1 hits: rule 2 never issued; 2-cycle start latency
        load_rule(0, R0); load_rule(1, R1); load_rule(2, R2);
        set_count(3);
        exp_rule_q.push_back(R0); exp_rule_q.push_back(R1);
        hit_q.push_back(0); hit_q.push_back(1);
        exp_match_q.push_back({R1.tx_addr, R1.pkt_len});
        pulse_start();
        @(negedge clk); chk("lat_fetch_no_valid", bus.rule_valid_o, 0);
        @(negedge clk); chk("lat_issue_valid", bus.rule_valid_o, 1);
        wait_for("t1_idle", 0, 100);
        chk("t1_rules_left", exp_rule_q.size(), 0);
        chk("t1_match_left", exp_match_q.size(), 0);

        // count=2, both miss: no match
        set_count(2);
        exp_rule_q.push_back(R0); exp_rule_q.push_back(R1);
        hit_q.push_back(0); hit_q.push_back(0);
        pulse_start();
        wait_for("t2_idle", 0, 100);
        chk("t2_rules_left", exp_rule_q.size(), 0);
        chk("t2_busy", bus.busy_o, 0);

        // Transmitter back-pressure for 5 cycles
        set_count(1);
        bus.match_ready_i = 1'b0;
        exp_rule_q.push_back(R0); hit_q.push_back(1);
        exp_match_q.push_back({R0.tx_addr, R0.pkt_len});
        pulse_start();
        wait_for("t3_match_valid", 2, 100);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk("t3_hold_valid", bus.match_valid_o, 1);
            chk("t3_hold_fields", {bus.match_addr_o, bus.match_pkt_len_o}, {R0.tx_addr, R0.pkt_len});
        end
        @(posedge clk); #1 bus.match_ready_i = 1'b1;
        @(negedge clk);
        @(negedge clk); chk("t3_valid_dropped", bus.match_valid_o, 0);
        chk("t3_match_left", exp_match_q.size(), 0);

        // Drops while busy, cfg write while busy ignored
        res_lat = 12;
        exp_rule_q.push_back(R0); hit_q.push_back(0);
        pulse_start();
        wait_for("t4_fire", 3, 50);
        pulse_start(); pulse_start(); pulse_start();
        load_rule(0, R2);
        chk("t4_cfg_ready_busy", bus.cfg_ready_o, 0);
        wait_for("t4_idle", 0, 100);
        chk("t4_drop_cnt", bus.drop_cnt_o, 3);
        res_lat = 1;
        exp_rule_q.push_back(R0); hit_q.push_back(0);
        pulse_start();
        wait_for("t4_idle2", 0, 100);
        chk("t4_table_kept", exp_rule_q.size(), 0);

        // Zero rules: start is neither processed nor dropped
        set_count(0);
        pulse_start();
        @(negedge clk); chk("t6_busy", bus.busy_o, 0);
        repeat (3) @(negedge clk);
        chk("t6_drop_same", bus.drop_cnt_o, 3);

        // Comparator stalls 4 cycles in ISSUE
        set_count(1);
        bus.rule_ready_i = 1'b0;
        exp_rule_q.push_back(R0); hit_q.push_back(0);
        pulse_start();
        wait_for("t5_rule_valid", 1, 50);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            chk("t5_stall_fields", {bus.rule_valid_o, bus.rule_byte_o, bus.rule_symbol_o, bus.rule_value_o},
                {1'b1, R0.byte_off, R0.symbol, R0.value});
        end
        @(posedge clk); #1 bus.rule_ready_i = 1'b1;
        wait_for("t5_idle", 0, 100);
        chk("t5_rules_left", exp_rule_q.size(), 0);

        // Reset in WAIT aborts without a match
        res_lat = 20;
        exp_rule_q.push_back(R0); hit_q.push_back(1);
        pulse_start();
        wait_for("t5r_fire", 3, 50);
        @(negedge clk); @(negedge clk);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("t5r_busy", bus.busy_o, 0);
        chk("t5r_cfg_ready", bus.cfg_ready_o, 1);
        chk("t5r_outputs", {bus.rule_valid_o, bus.match_valid_o, bus.rule_byte_o, bus.rule_symbol_o,
                            bus.rule_value_o, bus.match_addr_o, bus.match_pkt_len_o, bus.drop_cnt_o}, 0);
        repeat (25) @(negedge clk);
        chk("t5r_no_match", bus.match_valid_o, 0);
        res_lat = 1;

        // Full depth: 256 rules, hit on the last one
        for (int i = 0; i < 256; i++) begin
            load_rule(i, mk(i));
            exp_rule_q.push_back(mk(i));
            hit_q.push_back(i == 255);
        end
        exp_match_q.push_back({8'hC3, 16'd772});
        set_count(256);
        pulse_start();
        wait_for("t7_idle", 0, 5000);
        chk("t7_rules_left", exp_rule_q.size(), 0);
        chk("t7_match_left", exp_match_q.size(), 0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
